// File: rtl/bcd_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sub_ctrl
// Brief    : Keypad-driven sequencer for a two-digit BCD subtractor. Collects
//            operands A and B from key events, captures the subtractor result
//            and drives three 7-segment digit codes for echo/result display.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sub_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] A2,
    output logic [3:0] A1,
    output logic [3:0] B2,
    output logic [3:0] B1,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    input  logic [3:0] minus,
    output logic [3:0] disp_sign,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic [1:0] state,
    output logic       done
);

    localparam logic [1:0] c_st_enter_a = 2'd0;
    localparam logic [1:0] c_st_enter_b = 2'd1;
    localparam logic [1:0] c_st_calc    = 2'd2;
    localparam logic [1:0] c_st_show    = 2'd3;

    localparam logic [3:0] c_key_enter  = 4'hA;
    localparam logic [3:0] c_key_clear  = 4'hB;
    localparam logic [3:0] c_glyph_min  = 4'd10;
    localparam logic [3:0] c_glyph_blank = 4'd15;

    logic [1:0] r_state;
    logic [3:0] r_a2, r_a1, r_b2, r_b1;
    logic [3:0] r_r2, r_r1, r_rm;
    logic       r_done;

    logic [1:0] w_state_nxt;
    logic [3:0] w_a2_nxt, w_a1_nxt, w_b2_nxt, w_b1_nxt;
    logic [3:0] w_r2_nxt, w_r1_nxt, w_rm_nxt;
    logic       w_done_nxt;

    logic w_is_digit, w_is_enter, w_is_clear, w_equal;

    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_enter = key_valid && (key_code == c_key_enter);
    assign w_is_clear = key_valid && (key_code == c_key_clear);
    // The subtractor output is undefined for equal operands, so that case
    // bypasses it entirely.
    assign w_equal    = ({r_a2, r_a1} == {r_b2, r_b1});

    // Next-state and next-register values; key events in CALC are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_a2_nxt    = r_a2;
        w_a1_nxt    = r_a1;
        w_b2_nxt    = r_b2;
        w_b1_nxt    = r_b1;
        w_r2_nxt    = r_r2;
        w_r1_nxt    = r_r1;
        w_rm_nxt    = r_rm;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_st_enter_a, c_st_enter_b, c_st_show: begin
                if (w_is_clear) begin
                    w_state_nxt = c_st_enter_a;
                    w_a2_nxt    = 4'd0;
                    w_a1_nxt    = 4'd0;
                    w_b2_nxt    = 4'd0;
                    w_b1_nxt    = 4'd0;
                    w_r2_nxt    = 4'd0;
                    w_r1_nxt    = 4'd0;
                    w_rm_nxt    = 4'd0;
                end else if (r_state == c_st_enter_a) begin
                    if (w_is_digit) begin
                        w_a2_nxt = r_a1;
                        w_a1_nxt = key_code;
                    end else if (w_is_enter) begin
                        w_state_nxt = c_st_enter_b;
                    end
                end else if (r_state == c_st_enter_b) begin
                    if (w_is_digit) begin
                        w_b2_nxt = r_b1;
                        w_b1_nxt = key_code;
                    end else if (w_is_enter) begin
                        w_state_nxt = c_st_calc;
                    end
                end else begin
                    // SHOW: a digit starts a new A entry, ENTER just restarts
                    if (w_is_digit || w_is_enter) begin
                        w_state_nxt = c_st_enter_a;
                        w_a2_nxt    = 4'd0;
                        w_a1_nxt    = w_is_digit ? key_code : 4'd0;
                        w_b2_nxt    = 4'd0;
                        w_b1_nxt    = 4'd0;
                    end
                end
            end
            default: begin
                // CALC: single cycle, capture result and move to SHOW
                w_state_nxt = c_st_show;
                w_done_nxt  = 1'b1;
                if (w_equal) begin
                    w_r2_nxt = 4'd0;
                    w_r1_nxt = 4'd0;
                    w_rm_nxt = 4'd0;
                end else begin
                    w_r2_nxt = s2;
                    w_r1_nxt = s1;
                    w_rm_nxt = minus;
                end
            end
        endcase
    end

    // State and data registers with synchronous reset overriding key events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_enter_a;
            r_a2    <= 4'd0;
            r_a1    <= 4'd0;
            r_b2    <= 4'd0;
            r_b1    <= 4'd0;
            r_r2    <= 4'd0;
            r_r1    <= 4'd0;
            r_rm    <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a2    <= w_a2_nxt;
            r_a1    <= w_a1_nxt;
            r_b2    <= w_b2_nxt;
            r_b1    <= w_b1_nxt;
            r_r2    <= w_r2_nxt;
            r_r1    <= w_r1_nxt;
            r_rm    <= w_rm_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Display selection: operand echo during entry, result in SHOW.
    always_comb begin
        disp_sign = c_glyph_blank;
        disp_tens = r_a2;
        disp_ones = r_a1;
        case (r_state)
            c_st_enter_b, c_st_calc: begin
                disp_tens = r_b2;
                disp_ones = r_b1;
            end
            c_st_show: begin
                disp_sign = (r_rm == c_glyph_min) ? c_glyph_min : c_glyph_blank;
                disp_tens = r_r2;
                disp_ones = r_r1;
            end
            default: begin
                disp_tens = r_a2;
                disp_ones = r_a1;
            end
        endcase
    end

    assign A2    = r_a2;
    assign A1    = r_a1;
    assign B2    = r_b2;
    assign B1    = r_b1;
    assign state = r_state;
    assign done  = r_done;

endmodule
`default_nettype wire
